// File: rtl/nx_axi4s_pkg.sv
// Shared defaults and types for the Nexus outbound AXI4-stream packetiser.
package nx_axi4s_pkg;

  localparam int NX_DATA_WIDTH  = 64;
  localparam int NX_DEPTH       = 16;
  localparam int NX_MAX_BEATS   = 8;
  localparam int NX_IDLE_CYCLES = 32;

  typedef struct packed {
    logic                     last;
    logic [NX_DATA_WIDTH-1:0] data;
  } nx_fifo_entry_t;

  // $clog2 floored at 1 so single-value counters still get a real bit
  function automatic int nx_clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nx_sync_fifo.sv
// Single-clock FIFO with occupancy count; rdata always shows the head entry.
module nx_sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   occ,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_OCC = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      occ_q, occ_d;
  logic             do_push, do_pop;

  assign full  = (occ_q == FULL_OCC);
  assign empty = (occ_q == '0);
  assign occ   = occ_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (do_push && !do_pop) begin
      occ_d = occ_q + (PW+1)'(1);
    end else if (!do_push && do_pop) begin
      occ_d = occ_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/nx_axi4s_packetiser.sv
// Re-frames the outbound Nexus stream into DMA packets closed by tlast,
// the beat limit, or an idle timeout, behind a registered output stage.
module nx_axi4s_packetiser
  import nx_axi4s_pkg::*;
#(
  parameter int DATA_WIDTH  = NX_DATA_WIDTH,
  parameter int DEPTH       = NX_DEPTH,
  parameter int MAX_BEATS   = NX_MAX_BEATS,
  parameter int IDLE_CYCLES = NX_IDLE_CYCLES
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [15:0]           pkt_count
);

  localparam int OW = $clog2(DEPTH) + 1;
  localparam int BW = nx_clog2_min1(MAX_BEATS);
  localparam int TW = $clog2(IDLE_CYCLES + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);
  localparam logic [TW-1:0] IDLE_MAX  = TW'(IDLE_CYCLES);

  logic [DATA_WIDTH:0]   fifo_rdata;
  logic [OW-1:0]         occ;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop, pop_last;
  logic                  head_last, at_limit, flush, occ_one, occ_ge2, can_load;

  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                  m_tlast_q, m_tlast_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic [15:0]           pkt_count_q, pkt_count_d;

  assign s_tready  = ~fifo_full;
  assign push      = s_tvalid & s_tready;
  assign m_tdata   = m_tdata_q;
  assign m_tlast   = m_tlast_q;
  assign m_tvalid  = m_tvalid_q;
  assign pkt_count = pkt_count_q;

  nx_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .wdata ({s_tlast, s_tdata}),
    .rdata (fifo_rdata),
    .occ   (occ),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A lone head beat is held back until something says the packet is over,
  // so a following beat can still join the same packet.
  always_comb begin
    head_last = fifo_rdata[DATA_WIDTH];
    at_limit  = (beat_cnt_q == LAST_BEAT);
    flush     = (timer_q == IDLE_MAX);
    occ_one   = (occ == OW'(1));
    occ_ge2   = (occ >= OW'(2));
    can_load  = ~m_tvalid_q | m_tready;
    pop       = can_load & (occ_ge2 | (occ_one & (head_last | at_limit | flush)));
    pop_last  = head_last | at_limit | (flush & occ_one);
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (pop) begin
      beat_cnt_d = pop_last ? '0 : beat_cnt_q + BW'(1);
    end

    timer_d = timer_q;
    if (push || (pop && pop_last)) begin
      timer_d = '0;
    end else if (!fifo_empty && timer_q != IDLE_MAX) begin
      timer_d = timer_q + TW'(1);
    end

    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    m_tvalid_d = m_tvalid_q;
    if (pop) begin
      m_tdata_d  = fifo_rdata[DATA_WIDTH-1:0];
      m_tlast_d  = pop_last;
      m_tvalid_d = 1'b1;
    end else if (m_tready) begin
      m_tvalid_d = 1'b0;
    end

    pkt_count_d = pkt_count_q;
    if (m_tvalid_q && m_tready && m_tlast_q) begin
      pkt_count_d = pkt_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt_q  <= '0;
      timer_q     <= '0;
      m_tdata_q   <= '0;
      m_tlast_q   <= 1'b0;
      m_tvalid_q  <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      timer_q     <= timer_d;
      m_tdata_q   <= m_tdata_d;
      m_tlast_q   <= m_tlast_d;
      m_tvalid_q  <= m_tvalid_d;
      pkt_count_q <= pkt_count_d;
    end
  end

endmodule

// File: tb/tb_nx_axi4s_packetiser.sv
// Directed bench for nx_axi4s_packetiser at default parameters.
module tb_nx_axi4s_packetiser;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] s_tdata;
  logic        s_tlast;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [15:0] pkt_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] out_d[$];
  logic        out_l[$];
  bit          mon_en = 1'b1;

  always #5 clk = ~clk;

  nx_axi4s_packetiser dut (
    .clk       (clk),
    .rstn      (rstn),
    .s_tdata   (s_tdata),
    .s_tlast   (s_tlast),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .pkt_count (pkt_count)
  );

  // Inputs change at posedge+1, so a negedge sample predicts the next edge.
  always @(negedge clk) begin
    if (mon_en && rstn && m_tvalid && m_tready) begin
      out_d.push_back(m_tdata);
      out_l.push_back(m_tlast);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_beat(input logic [63:0] d, input logic l);
    int waited;
    waited = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!s_tready) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: s_tready=%b required 1", s_tready);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input int budget);
    int cyc;
    cyc = 0;
    while (out_d.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (out_d.size() < n) begin
      n_cmp++;
      n_err++;
      $display("FAIL out_timeout: got %0d beats required %0d", out_d.size(), n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b required 0", m_tvalid); end
    n_cmp++; if (m_tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast: got %b required 0", m_tlast); end
    n_cmp++; if (m_tdata !== 64'h0) begin n_err++; $display("FAIL rst_tdata: got %h required 0", m_tdata); end
    n_cmp++; if (pkt_count !== 16'h0) begin n_err++; $display("FAIL rst_pkt_count: got %0d required 0", pkt_count); end
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL rst_tready: got %b required 1", s_tready); end
  endtask

  task automatic test_limit_framing();
    logic el;
    out_d.delete(); out_l.delete();
    m_tready = 1'b1;
    for (int i = 1; i <= 20; i++) push_beat(64'h1000 + 64'(i), (i == 20));
    wait_outputs(20, 100);
    for (int i = 0; i < 20; i++) begin
      el = (i == 7 || i == 15 || i == 19);
      n_cmp++;
      if (out_d[i] !== 64'h1001 + 64'(i) || out_l[i] !== el) begin
        n_err++;
        $display("FAIL limit_beat%0d: got %h/%b required %h/%b", i, out_d[i], out_l[i], 64'h1001 + 64'(i), el);
      end
    end
    n_cmp++; if (pkt_count !== 16'd3) begin n_err++; $display("FAIL limit_pkt_count: got %0d required 3", pkt_count); end
  endtask

  task automatic test_idle_flush();
    int          first;
    logic [63:0] fd;
    logic        fl;
    first = -1; fd = '0; fl = 1'b0;
    out_d.delete(); out_l.delete();
    m_tready = 1'b1;
    push_beat(64'hA5, 1'b0);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (m_tvalid && first < 0) begin
        first = c; fd = m_tdata; fl = m_tlast;
      end
    end
    n_cmp++; if (first != 33) begin n_err++; $display("FAIL idle_latency: got %0d required 33", first); end
    n_cmp++; if (fd !== 64'hA5 || fl !== 1'b1) begin n_err++; $display("FAIL idle_beat: got %h/%b required a5/1", fd, fl); end
    n_cmp++; if (dut.beat_cnt_q !== 3'd0) begin n_err++; $display("FAIL idle_beat_cnt: got %0d required 0", dut.beat_cnt_q); end
    n_cmp++; if (pkt_count !== 16'd4) begin n_err++; $display("FAIL idle_pkt_count: got %0d required 4", pkt_count); end
  endtask

  task automatic test_backpressure();
    int   bad;
    logic el;
    out_d.delete(); out_l.delete();
    m_tready = 1'b0;
    for (int i = 0; i < 17; i++) push_beat(64'h2000 + 64'(i), 1'b0);
    @(negedge clk);
    n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL bp_full_tready: got %b required 0", s_tready); end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (m_tvalid !== 1'b1 || m_tdata !== 64'h2000 || s_tready !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL bp_hold: got %0d unstable cycles required 0", bad); end
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    wait_outputs(17, 200);
    for (int i = 0; i < 17; i++) begin
      el = (i == 7 || i == 15 || i == 16);
      n_cmp++;
      if (out_d[i] !== 64'h2000 + 64'(i) || out_l[i] !== el) begin
        n_err++;
        $display("FAIL bp_beat%0d: got %h/%b required %h/%b", i, out_d[i], out_l[i], 64'h2000 + 64'(i), el);
      end
    end
    n_cmp++; if (pkt_count !== 16'd7) begin n_err++; $display("FAIL bp_pkt_count: got %0d required 7", pkt_count); end
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL bp_tready_after: got %b required 1", s_tready); end
  endtask

  task automatic test_stall_flush();
    int          waited, bad;
    logic        hold;
    logic [63:0] pd;
    logic        pl;
    logic [63:0] exp_d [3];
    logic        exp_l [3];
    exp_d[0] = 64'h11; exp_l[0] = 1'b1;
    exp_d[1] = 64'h22; exp_l[1] = 1'b0;
    exp_d[2] = 64'h33; exp_l[2] = 1'b1;
    out_d.delete(); out_l.delete();
    m_tready = 1'b0;
    push_beat(64'h11, 1'b0);
    waited = 0;
    while (!m_tvalid && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== 64'h11 || m_tlast !== 1'b1) begin
      n_err++; $display("FAIL stall_flush_load: got %b/%h/%b required 1/11/1", m_tvalid, m_tdata, m_tlast);
    end
    @(posedge clk);
    #1;
    push_beat(64'h22, 1'b0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (m_tdata !== 64'h11 || m_tlast !== 1'b1 || m_tvalid !== 1'b1) bad++;
    end
    @(posedge clk);
    #1;
    push_beat(64'h33, 1'b1);
    hold = 1'b0; pd = '0; pl = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (hold && (m_tvalid !== 1'b1 || m_tdata !== pd || m_tlast !== pl)) bad++;
      hold = m_tvalid && !m_tready;
      pd   = m_tdata;
      pl   = m_tlast;
      @(posedge clk);
      #1;
      m_tready = ~m_tready;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL stall_stability: got %0d unstable cycles required 0", bad); end
    m_tready = 1'b1;
    wait_outputs(3, 20);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_d[i] !== exp_d[i] || out_l[i] !== exp_l[i]) begin
        n_err++;
        $display("FAIL stall_beat%0d: got %h/%b required %h/%b", i, out_d[i], out_l[i], exp_d[i], exp_l[i]);
      end
    end
    n_cmp++; if (pkt_count !== 16'd9) begin n_err++; $display("FAIL stall_pkt_count: got %0d required 9", pkt_count); end
  endtask

  task automatic test_reset_mid();
    logic el;
    logic [63:0] ed;
    out_d.delete(); out_l.delete();
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) push_beat(64'h30 + 64'(i), 1'b0);
    n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== 64'h30) begin n_err++; $display("FAIL mid_preload: got %b/%h required 1/30", m_tvalid, m_tdata); end
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_rst_tvalid: got %b required 0", m_tvalid); end
    n_cmp++; if (m_tlast !== 1'b0 || m_tdata !== 64'h0) begin n_err++; $display("FAIL mid_rst_or: got %b/%h required 0/0", m_tlast, m_tdata); end
    n_cmp++; if (pkt_count !== 16'h0) begin n_err++; $display("FAIL mid_rst_pkt_count: got %0d required 0", pkt_count); end
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL mid_rst_tready: got %b required 1", s_tready); end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (dut.beat_cnt_q !== 3'd0) begin n_err++; $display("FAIL mid_beat_cnt: got %0d required 0", dut.beat_cnt_q); end
    m_tready = 1'b1;
    push_beat(64'h40, 1'b1);
    n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_early_valid: got %b required 0", m_tvalid); end
    @(posedge clk);
    #1;
    n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== 64'h40 || m_tlast !== 1'b1) begin
      n_err++; $display("FAIL mid_latency: got %b/%h/%b required 1/40/1", m_tvalid, m_tdata, m_tlast);
    end
    for (int i = 0; i < 9; i++) push_beat(64'h50 + 64'(i), (i == 8));
    wait_outputs(10, 60);
    for (int i = 0; i < 10; i++) begin
      ed = (i == 0) ? 64'h40 : 64'h4F + 64'(i);
      el = (i == 0 || i == 8 || i == 9);
      n_cmp++;
      if (out_d[i] !== ed || out_l[i] !== el) begin
        n_err++;
        $display("FAIL mid_beat%0d: got %h/%b required %h/%b", i, out_d[i], out_l[i], ed, el);
      end
    end
    n_cmp++; if (pkt_count !== 16'd3) begin n_err++; $display("FAIL mid_pkt_count: got %0d required 3", pkt_count); end
  endtask

  task automatic test_pkt_wrap();
    do_reset();
    mon_en   = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 65535; i++) push_beat(64'(i), 1'b1);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (pkt_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_max: got %0d required 65535", pkt_count); end
    push_beat(64'hF0, 1'b1);
    push_beat(64'hF1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (pkt_count !== 16'd1) begin n_err++; $display("FAIL wrap_one: got %0d required 1", pkt_count); end
    mon_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_limit_framing();
    test_idle_flush();
    test_backpressure();
    test_stall_flush();
    test_reset_mid();
    test_pkt_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nx_axi4s_packetiser.md
# nx_axi4s_packetiser

Outbound packet-framing stage between the FPGA Nexus instance's outbound AXI4-stream (control or mesh) and the host DMA engine. Buffers beats in a FIFO and re-frames them into DMA packets of at most MAX_BEATS beats. A packet is closed by upstream `tlast`, by reaching the beat limit, or by an idle timeout, so a trickling message stream never stalls in a partially filled DMA packet.

## Interface
- `DATA_WIDTH`, 64, AXI4-stream data width on both sides.
- `DEPTH`, 16, FIFO entries, power of two, ≥2.
- `MAX_BEATS`, 8, maximum beats per outbound packet, ≥1.
- `IDLE_CYCLES`, 32, idle cycles before a partial packet is flushed, ≥1.
- `clk`  in  1  single clock, all logic rising-edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `s_tdata`  in  DATA_WIDTH  upstream beat data.
- `s_tlast`  in  1  upstream end-of-packet.
- `s_tvalid`  in  1  upstream beat valid.
- `s_tready`  out  1  FIFO can accept.
- `m_tdata`  out  DATA_WIDTH  DMA beat data (registered).
- `m_tlast`  out  1  DMA end-of-packet (registered).
- `m_tvalid`  out  1  DMA beat valid (registered).
- `m_tready`  in  1  DMA accepts.
- `pkt_count`  out  16  packets emitted, wraps at 2^16.

## Operation
- Push: `s_tvalid & s_tready` writes {data, last} at the FIFO tail. `s_tready = (occ != DEPTH)`. When full, `s_tready` is 0 even if a pop occurs the same cycle (no full-bypass).
- Output register (OR) holds {data, last}. `m_tvalid` = OR full.
- Pop into OR when `(!m_tvalid | m_tready)` and release holds:
  - `occ ≥ 2`, or
  - `occ == 1` and (`head.last` | `beat_cnt == MAX_BEATS-1` | `flush`).
- Popped `last = head.last | (beat_cnt == MAX_BEATS-1) | (flush & occ == 1)`.
- `beat_cnt` (width `$clog2(MAX_BEATS)`, min 1) increments on each pop. It clears to 0 on a pop whose `last = 1`.
- Idle timer (width `$clog2(IDLE_CYCLES+1)`):
  - clears on any push, and on any pop with `last = 1`;
  - otherwise increments while `occ ≥ 1`, saturating at IDLE_CYCLES.
  - `flush = (timer == IDLE_CYCLES)`.
- Once loaded, OR contents, including `m_tlast`, stay stable until `m_tvalid & m_tready`. AXI stability is never violated.
- `pkt_count` increments on each output handshake with `m_tlast = 1`.
- Simultaneous push and pop with `occ == 1`: the pop sees the pre-push occupancy. The head releases only if a last/limit/flush condition holds. Otherwise the pushed beat makes `occ = 2` and the head releases next cycle without `last`.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `occ` is `$clog2(DEPTH)+1` bits.

## Timing
- Reset values: `m_tvalid = 0`, `m_tlast = 0`, `m_tdata = 0`, `pkt_count = 0`, `s_tready = 1`. Internal: `beat_cnt = 0`, timer 0, FIFO empty.
- Reset mid-operation discards FIFO and OR contents; no partial packet is completed.
- Minimum latency from push to `m_tvalid`:
  - 2 cycles if the beat is releasable on arrival (`s_tlast`, or beat limit reached);
  - otherwise 2 cycles after the next push.
- Unterminated lone beat: `m_tvalid` rises IDLE_CYCLES+1 cycles after its push, with `m_tlast = 1`.
- Sustained throughput: 1 beat/cycle when `occ ≥ 2` and `m_tready = 1`.

## Structure
- Shared package `nx_axi4s_pkg`: default `DATA_WIDTH`, `MAX_BEATS`, `IDLE_CYCLES` constants, and the FIFO entry typedef `{logic last; logic [DATA_WIDTH-1:0] data;}`.
- Sub-module `nx_sync_fifo`: pointers, occupancy, storage, and push/pop with full/empty flags.
- Top level: release logic, `beat_cnt`, idle timer, output register, `pkt_count`.

## Test plan
- 20 beats back-to-back, `s_tlast` only on beat 20, `MAX_BEATS = 8`, `m_tready = 1` -> packets of 8, 8, 4 beats; `m_tlast` on beats 8, 16, 20; `pkt_count = 3`.
- Single beat `0xA5`, no `s_tlast`, `IDLE_CYCLES = 32` -> `m_tvalid` at cycle 33 after push with `m_tlast = 1`; `beat_cnt` back to 0.
- `m_tready = 0` while 17 beats are offered, `DEPTH = 16` -> `s_tready` drops after 16 FIFO beats plus 1 in OR. With `m_tready` released, all 17 emerge in order, data unchanged.
- `m_tready` toggling every cycle during a flush, with a new push arriving while the flushed beat is in OR -> `m_tdata`/`m_tlast` held stable until handshake; the new beat starts a new packet.
- `rstn` asserted mid-packet with 5 beats buffered -> all outputs at reset values immediately; after release, `s_tready = 1` and the next packet starts with `beat_cnt = 0`.
- 65537 single-beat `tlast` packets -> `pkt_count` wraps to 1.
